// File: rtl/shift_pkg.sv
// Shared definitions for the serializer and the downstream serial shift chain.
package shift_pkg;

  localparam int unsigned DefaultWidth = 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable up-counter with a terminal-count flag.
module piso_bit_counter #(
  parameter int unsigned Width    = 2,
  parameter int unsigned Terminal = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic             tc
);

  localparam logic [Width-1:0] TermVal = Width'(Terminal);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + Width'(1);
    end
  end

  assign tc = (count == TermVal);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with valid/ready input, framing strobes and optional idle gap.
module piso_serializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pdata,
  input  logic             pvalid,
  output logic             pready,
  output logic             dout,
  output logic             dvalid,
  output logic             sof,
  output logic             eof
);

  localparam int unsigned BitW    = cnt_width(WIDTH);
  localparam int unsigned GapW    = cnt_width(GAP_CYCLES + 1);
  localparam int unsigned GapTerm = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [BitW-1:0] EofPre = BitW'(WIDTH - 2);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic [BitW-1:0]  bit_cnt;
  logic             bit_tc, bit_load, bit_en;
  logic [GapW-1:0]  gap_cnt;
  logic             gap_tc, gap_load, gap_en;
  logic             unused_gap_cnt;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Rotate rather than shift so the next bit to emit always sits at the output end.
  function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], w[WIDTH-1]} : {w[0], w[WIDTH-1:1]};
  endfunction

  assign pready = (state_q == StIdle) ||
                  ((state_q == StShift) && bit_tc && (GAP_CYCLES == 0));
  assign accept = pvalid && pready;
  assign unused_gap_cnt = ^gap_cnt;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    dout_d   = 1'b0;
    dvalid_d = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    bit_load = 1'b0;
    bit_en   = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StShift;
          sreg_d   = pdata;
          dout_d   = first_bit(pdata);
          dvalid_d = 1'b1;
          sof_d    = 1'b1;
          bit_load = 1'b1;
        end
      end
      StShift: begin
        if (!bit_tc) begin
          sreg_d   = rot(sreg_q);
          dout_d   = first_bit(rot(sreg_q));
          dvalid_d = 1'b1;
          eof_d    = (bit_cnt == EofPre);
          bit_en   = 1'b1;
        end else begin
          bit_load = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
          end else if (accept) begin
            sreg_d   = pdata;
            dout_d   = first_bit(pdata);
            dvalid_d = 1'b1;
            sof_d    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_tc) begin
          state_d  = StIdle;
          gap_load = 1'b1;
        end else begin
          gap_en = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sreg_q   <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
    end
  end

  piso_bit_counter #(
    .Width    (BitW),
    .Terminal (WIDTH - 1)
  ) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bit_load),
    .load_val ('0),
    .en       (bit_en),
    .count    (bit_cnt),
    .tc       (bit_tc)
  );

  piso_bit_counter #(
    .Width    (GapW),
    .Terminal (GapTerm)
  ) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val ('0),
    .en       (gap_en),
    .count    (gap_cnt),
    .tc       (gap_tc)
  );

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign sof    = sof_q;
  assign eof    = eof_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: dut0 MSB-first no gap, dut1 LSB-first no gap, dut2 MSB-first with 2-cycle gap.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pdata [3];
  logic [2:0] pvalid;
  wire  [2:0] pready, dout, dvalid, sof, eof;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Expected {dout, sof, eof} per emitted bit, one queue per DUT.
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [2:0] q2[$];

  int since_eof[3] = '{0, 0, 0};
  int dead_cnt[3]  = '{0, 0, 0};
  int last_gap[3]  = '{0, 0, 0};
  int last_dead[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pdata(pdata[0]), .pvalid(pvalid[0]), .pready(pready[0]),
    .dout(dout[0]), .dvalid(dvalid[0]), .sof(sof[0]), .eof(eof[0])
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .pdata(pdata[1]), .pvalid(pvalid[1]), .pready(pready[1]),
    .dout(dout[1]), .dvalid(dvalid[1]), .sof(sof[1]), .eof(eof[1])
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pdata(pdata[2]), .pvalid(pvalid[2]), .pready(pready[2]),
    .dout(dout[2]), .dvalid(dvalid[2]), .sof(sof[2]), .eof(eof[2])
  );

  task automatic chk(input int i, input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", i, name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [2:0] qpop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int i, input logic [2:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a frame bit.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < 3; i++) begin
          since_eof[i]++;
          if (dvalid[i] === 1'b1) begin
            if (qsize(i) == 0) begin
              checks++;
              errors++;
              $display("FAIL dut%0d unexpected_bit: got dvalid 1 expected 0 at %0t", i, $time);
            end else begin
              chk(i, "frame_bit", {5'd0, dout[i], sof[i], eof[i]}, {5'd0, qpop(i)});
            end
            if (sof[i]) begin
              last_gap[i]  = since_eof[i];
              last_dead[i] = dead_cnt[i];
            end
            if (eof[i]) begin
              chk(i, "eof_pready", {7'd0, pready[i]}, (i != 2) ? 8'd1 : 8'd0);
              since_eof[i] = 0;
              dead_cnt[i]  = 0;
            end
          end else begin
            chk(i, "idle_outputs", {5'd0, dout[i], sof[i], eof[i]}, 8'd0);
            if (pready[i] === 1'b0) dead_cnt[i]++;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // seq lists the expected dout values in emission order, first bit in seq[3].
  task automatic send(input int i, input logic [3:0] d, input logic [3:0] seq);
    bit done = 1'b0;
    pdata[i]  = d;
    pvalid[i] = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (pready[i] === 1'b1) begin
        for (int b = 0; b < 4; b++) qpush(i, {seq[3-b], b == 0, b == 3});
        done = 1'b1;
      end
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL dut%0d send_timeout: got pready 0 expected 1 within 40 cycles", i);
      pvalid[i] = 1'b0;
    end
  endtask

  task automatic idle(input int i);
    pvalid[i] = 1'b0;
    pdata[i]  = 4'h0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && k < 60) begin
      step();
      k++;
    end
    checks++;
    if (k >= 60) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending bits expected 0",
               q0.size() + q1.size() + q2.size());
    end
    repeat (3) step();
  endtask

  initial begin
    rst_n  = 1'b0;
    pvalid = 3'b111;
    for (int i = 0; i < 3; i++) pdata[i] = 4'hF;
    @(posedge clk);
    mon_en = 1'b1;
    // Reset held over three edges with pvalid asserted.
    for (int c = 0; c < 3; c++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        chk(i, "reset_dvalid", {7'd0, dvalid[i]}, 8'd0);
        chk(i, "reset_dout", {7'd0, dout[i]}, 8'd0);
        chk(i, "reset_sof_eof", {6'd0, sof[i], eof[i]}, 8'd0);
      end
    end
    rst_n  = 1'b1;
    pvalid = 3'b000;
    step();
    for (int i = 0; i < 3; i++) chk(i, "ready_after_reset", {7'd0, pready[i]}, 8'd1);

    // Single MSB-first frame; pdata changes right after accept.
    send(0, 4'b1011, 4'b1011);
    idle(0);
    drain();

    // LSB-first.
    send(1, 4'b1011, 4'b1101);
    idle(1);
    drain();

    // Back-to-back with no gap: no bubble between frames.
    send(0, 4'hA, 4'b1010);
    send(0, 4'h5, 4'b0101);
    idle(0);
    drain();
    chk(0, "b2b_eof_to_sof", last_gap[0][7:0], 8'd1);
    chk(0, "b2b_dead_cycles", last_dead[0][7:0], 8'd0);

    // Two queued words with a 2-cycle gap, then one IDLE accept cycle.
    send(2, 4'b1011, 4'b1011);
    send(2, 4'b0110, 4'b0110);
    idle(2);
    drain();
    chk(2, "gap_dead_cycles", last_dead[2][7:0], 8'd2);
    chk(2, "gap_eof_to_sof", last_gap[2][7:0], 8'd4);

    // Same two words on the no-gap LSB DUT.
    send(1, 4'b1011, 4'b1101);
    send(1, 4'b0110, 4'b0110);
    idle(1);
    drain();
    chk(1, "lsb_b2b_eof_to_sof", last_gap[1][7:0], 8'd1);

    // Reset mid-frame, after bit 2 of 4'b1111.
    send(0, 4'b1111, 4'b1111);
    idle(0);
    step();
    step();
    rst_n = 1'b0;
    q0.delete();
    step();
    chk(0, "abort_dvalid", {7'd0, dvalid[0]}, 8'd0);
    chk(0, "abort_dout", {7'd0, dout[0]}, 8'd0);
    chk(0, "abort_eof", {7'd0, eof[0]}, 8'd0);
    rst_n = 1'b1;
    send(0, 4'b1001, 4'b1001);
    idle(0);
    drain();
    chk(0, "post_abort_eof_to_sof", (last_gap[0] > 1) ? 8'd1 : 8'd0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
